// File: rtl/aidc_lite_block_packer.sv
// Two-bank ping-pong buffer that captures one addressed block of code words while
// the previous closed block streams out in word order over valid/ready.
module aidc_lite_block_packer #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic [3:0]        addr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              last_i,
    input  logic [10:0]       blk_size_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              sop_o,
    output logic              eop_o,
    output logic [DATA_W-1:0] data_o,
    output logic [4:0]        nwords_o,
    output logic [10:0]       blk_size_o,
    output logic              overflow_o
);
    localparam int AW   = $clog2(DEPTH);
    localparam int NW_W = AW + 1;

    typedef enum logic {IDLE, SEND} state_e;

    state_e                     state_q, state_d;
    logic [1:0]                 full_q, full_d;
    logic [1:0][NW_W-1:0]       nwords_q, nwords_d;
    logic [1:0][10:0]           size_q, size_d;
    logic                       wr_bank_q, wr_bank_d;
    logic                       rd_bank_q, rd_bank_d;
    logic [AW-1:0]              rd_ptr_q, rd_ptr_d;
    logic                       overflow_q, overflow_d;
    logic [DATA_W-1:0]          bank_q [2][DEPTH];

    logic            wr_ok, close, big, hs, eop;
    logic [10:0]     size_cl, size_rnd;
    logic [NW_W-1:0] nw_calc;

    always_comb begin
        wr_ok    = valid_i & ~full_q[wr_bank_q];
        close    = wr_ok & last_i;
        big      = blk_size_i > 11'd1024;
        size_cl  = big ? 11'd1024 : blk_size_i;
        // 1024+63 still fits in 11 bits, so the rounding add cannot wrap
        size_rnd = size_cl + 11'd63;
        nw_calc  = (size_cl == 11'd0) ? NW_W'(1) : size_rnd[10:6];
        hs       = (state_q == SEND) & ready_i;
        eop      = (state_q == SEND) &
                   ({1'b0, rd_ptr_q} == nwords_q[rd_bank_q] - NW_W'(1));
    end

    always_comb begin
        full_d     = full_q;
        nwords_d   = nwords_q;
        size_d     = size_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q | (valid_i & (full_q[wr_bank_q] | (last_i & big)));
        if (close) begin
            size_d[wr_bank_q]   = size_cl;
            nwords_d[wr_bank_q] = nw_calc;
            full_d[wr_bank_q]   = 1'b1;
            wr_bank_d           = ~wr_bank_q;
        end
        if (hs) begin
            if (eop) begin
                rd_ptr_d          = '0;
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end else begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
        end
        // Looking at next-state full lets a fresh close show sop one cycle later
        // and lets a same-cycle close on the other bank follow eop without a bubble.
        state_d = full_d[rd_bank_d] ? SEND : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            full_q     <= '0;
            nwords_q   <= '0;
            size_q     <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            full_q     <= full_d;
            nwords_q   <= nwords_d;
            size_q     <= size_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Word storage is not reset; unwritten addresses read back stale data.
    always_ff @(posedge clk) begin
        if (wr_ok) bank_q[wr_bank_q][addr_i[AW-1:0]] <= data_i;
    end

    always_comb begin
        valid_o    = 1'b0;
        sop_o      = 1'b0;
        eop_o      = 1'b0;
        data_o     = '0;
        nwords_o   = '0;
        blk_size_o = '0;
        if (state_q == SEND) begin
            valid_o    = 1'b1;
            sop_o      = (rd_ptr_q == '0);
            eop_o      = eop;
            data_o     = bank_q[rd_bank_q][rd_ptr_q];
            nwords_o   = nwords_q[rd_bank_q];
            blk_size_o = size_q[rd_bank_q];
        end
    end

    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_aidc_lite_block_packer.sv
// Scoreboard bench for aidc_lite_block_packer: stimulus pushes expected beats,
// a negedge monitor pops and compares every handshake and checks stall stability.
module tb_aidc_lite_block_packer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic [3:0]  addr_i;
    logic [63:0] data_i;
    logic        last_i;
    logic [10:0] blk_size_i;
    logic        valid_o;
    logic        ready_i;
    logic        sop_o;
    logic        eop_o;
    logic [63:0] data_o;
    logic [4:0]  nwords_o;
    logic [10:0] blk_size_o;
    logic        overflow_o;

    aidc_lite_block_packer dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .addr_i(addr_i), .data_i(data_i),
        .last_i(last_i), .blk_size_i(blk_size_i), .valid_o(valid_o), .ready_i(ready_i),
        .sop_o(sop_o), .eop_o(eop_o), .data_o(data_o), .nwords_o(nwords_o),
        .blk_size_o(blk_size_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [63:0] data;
        logic [4:0]  nw;
        logic [10:0] sz;
    } beat_t;

    beat_t exp_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] word(input int b, input int a);
        return {16'hB10C, 16'(b), 16'hD00D, 16'(a)};
    endfunction

    // Monitor: compare each handshake against the scoreboard; hold check on stalls.
    beat_t prev;
    logic  prev_stall = 1'b0;
    always @(negedge clk) begin
        beat_t cur, e;
        cur = '{sop: sop_o, eop: eop_o, data: data_o, nw: nwords_o, sz: blk_size_o};
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) chk("stall_hold", 64'(cur != prev || !valid_o), 64'd0);
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", data_o, 64'hDEAD_DEAD_DEAD_DEAD);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", cur.data, e.data);
                    chk("beat_sop", 64'(cur.sop), 64'(e.sop));
                    chk("beat_eop", 64'(cur.eop), 64'(e.eop));
                    chk("beat_nwords", 64'(cur.nw), 64'(e.nw));
                    chk("beat_size", 64'(cur.sz), 64'(e.sz));
                end
            end
            prev       = cur;
            prev_stall = valid_o && !ready_i;
        end
    end

    task automatic wr(input int a, input logic [63:0] d, input logic last, input int sz);
        addr_i     = 4'(a);
        data_i     = d;
        last_i     = last;
        blk_size_i = 11'(sz);
        valid_i    = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    // Writes n words of block b, closing on the last; pushes expected beats if accepted.
    task automatic block(input int b, input int n, input int sz, input int enw,
                         input int esz, input bit accept);
        beat_t e;
        if (accept) begin
            for (int a = 0; a < enw; a++) begin
                e = '{sop: (a == 0), eop: (a == enw - 1), data: word(b, a),
                      nw: 5'(enw), sz: 11'(esz)};
                exp_q.push_back(e);
            end
        end
        for (int a = 0; a < n; a++) wr(a, word(b, a), (a == n - 1), sz);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_valid"}, 64'(valid_o), 64'd0);
        chk({tag, "_sop"}, 64'(sop_o), 64'd0);
        chk({tag, "_eop"}, 64'(eop_o), 64'd0);
        chk({tag, "_data"}, data_o, 64'd0);
        chk({tag, "_nwords"}, 64'(nwords_o), 64'd0);
        chk({tag, "_size"}, 64'(blk_size_o), 64'd0);
        chk({tag, "_overflow"}, 64'(overflow_o), 64'd0);
    endtask

    task automatic wait_empty(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk); #1;
        end
        chk("drain_done", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; valid_i = 1'b0; addr_i = '0; data_i = '0;
        last_i = 1'b0; blk_size_i = '0; ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 3-word block, size 150 -> 3 words, sop one cycle after close, no gaps
        ready_i = 1'b1;
        block(0, 3, 150, 3, 150, 1'b1);
        chk("t1_latency_valid", 64'(valid_o), 64'd1);
        chk("t1_latency_sop", 64'(sop_o), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("t1_consecutive", 64'(exp_q.size()), 64'd0);
        chk("t1_idle_after", 64'(valid_o), 64'd0);

        // Single-word block, size 2
        block(1, 1, 2, 1, 2, 1'b1);
        chk("t2_sop_eop", 64'({sop_o, eop_o}), 64'b11);
        @(posedge clk); #1;
        chk("t2_done", 64'(exp_q.size()), 64'd0);

        // Two full blocks buffered with the sink stalled
        ready_i = 1'b0;
        block(2, 16, 1024, 16, 1024, 1'b1);
        block(3, 16, 1000, 16, 1000, 1'b1);
        chk("t3_no_overflow", 64'(overflow_o), 64'd0);

        // Third block while both banks are full is dropped
        block(4, 3, 100, 0, 0, 1'b0);
        chk("t4_overflow", 64'(overflow_o), 64'd1);
        ready_i = 1'b1;
        repeat (32) @(posedge clk);
        #1;
        chk("t3_no_gap_32", 64'(exp_q.size()), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("t4_third_not_output", 64'(valid_o), 64'd0);

        // 5-word block, size 300, with a randomly stalling sink
        fork
            block(5, 5, 300, 5, 300, 1'b1);
            for (int i = 0; i < 40; i++) begin
                ready_i = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
        join
        ready_i = 1'b1;
        wait_empty(50);

        // Clamp on an oversized block, then reset mid-drain
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("reset2");
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        block(6, 16, 1500, 16, 1024, 1'b1);
        chk("t6_overflow", 64'(overflow_o), 64'd1);
        chk("t6_nwords", 64'(nwords_o), 64'd16);
        chk("t6_size", 64'(blk_size_o), 64'd1024);
        repeat (4) @(posedge clk);
        #3;
        chk("t6_mid_drain", 64'(valid_o), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("midrst");
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_reset_idle", 64'(valid_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/aidc_lite_block_packer.md
# aidc_lite_block_packer

Downstream stage of the AIDC-Lite code concatenator. Captures the addressed 64-bit code words of one compressed block into a 2-bank ping-pong buffer (16 words per bank), closes the block on `last_i`, and streams it out in word order over a valid/ready interface. Each word carries the block's word count and bit size. The upstream concatenator has no backpressure, so this block absorbs one block while draining the previous one.

## Interface
- `DEPTH`, 16: words per bank. Address width is 4.
- `DATA_W`, 64: code word width.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `valid_i`  in  1  write strobe for `data_i` at `addr_i`; no backpressure.
- `addr_i`  in  4  word index within the current block.
- `data_i`  in  64  code word.
- `last_i`  in  1  closes the current block; qualified by `valid_i` and may share a cycle with the final word write.
- `blk_size_i`  in  11  total block bits; sampled only when `valid_i & last_i`.
- `valid_o`  out  1  output word valid.
- `ready_i`  in  1  sink accepts the word.
- `sop_o`  out  1  first word of a block.
- `eop_o`  out  1  last word of a block.
- `data_o`  out  64  output word.
- `nwords_o`  out  5  words in the current output block, range 1..16.
- `blk_size_o`  out  11  latched `blk_size_i` of the current output block.
- `overflow_o`  out  1  sticky error: a write or close was dropped, or the size was clamped.

## Operation
- **Storage:** `bank[2][16]` x 64 flops. Per-bank registers: `full`, `nwords` (5 b), `size` (11 b). Pointers: `wr_bank`, `rd_bank` (1 b each, 0 after reset), `rd_ptr` (4 b).
- **Write side:**
  - On `valid_i`, if `!full[wr_bank]`, write `bank[wr_bank][addr_i] <= data_i`.
  - On `valid_i & last_i` with `!full[wr_bank]`:
    - `size[wr_bank] <= min(blk_size_i, 1024)`.
    - `nwords[wr_bank] <= max(1, ceil(size/64))`, computed as `(size+63)>>6`, forced to 1 when size is 0.
    - `full[wr_bank] <= 1`, then toggle `wr_bank`.
  - `blk_size_i > 1024` clamps to 1024 and sets `overflow_o`.
- **Overflow:** `valid_i` while `full[wr_bank]` drops the write (and the close, if `last_i`) and sets `overflow_o`. Only reset clears `overflow_o`. Bank contents are unaffected.
- **Read side (2 states):**
  - IDLE: `valid_o = 0`. Moves to SEND when `full[rd_bank]`.
  - SEND: the following are driven combinationally from registers:
    - `valid_o = 1`.
    - `data_o = bank[rd_bank][rd_ptr]`.
    - `sop_o = (rd_ptr == 0)`.
    - `eop_o = (rd_ptr == nwords[rd_bank]-1)`.
    - `nwords_o = nwords[rd_bank]`, `blk_size_o = size[rd_bank]`.
  - A handshake (`valid_o & ready_i`) on a non-eop word increments `rd_ptr`.
  - A handshake on the eop word sets `rd_ptr <= 0`, `full[rd_bank] <= 0`, toggles `rd_bank`, and goes to IDLE, or stays in SEND if the other bank is already full.
- **Word contents:** addresses never written in a block return stale bank contents; this is not an error. Addresses at or beyond `nwords` are written but never read.
- **Simultaneous events:**
  - A close on one bank and the eop drain of the other bank in the same cycle both take effect.
  - A write to a bank in the same cycle its `full` clears (drain eop) is dropped, because `full` is sampled pre-edge.

## Timing
- **Reset values:** `valid_o=0`, `sop_o=0`, `eop_o=0`, `data_o=0`, `nwords_o=0`, `blk_size_o=0`, `overflow_o=0`. Also `full=0`, both pointers 0, `rd_ptr=0`, state IDLE.
- **Reset mid-operation:** asynchronously discards all buffered blocks and any partial block.
- **Latency:** close in cycle N gives `valid_o=1`, `sop_o=1` in cycle N+1 when the read side is idle on that bank.
- **Throughput:** 1 word/cycle with `ready_i` held high.
- **Back-to-back blocks:** eop handshake in cycle M gives the next block's sop in cycle M+1 if its bank is full. There are no bubbles.
- **Output stability:** while `valid_o & !ready_i`, all outputs hold stable.
- **Single-word block:** `sop_o` and `eop_o` are both 1 on the same beat.
- **Capacity:** two closed blocks maximum. A third block's writes are dropped until a drain eop completes.

## Test plan
- Reset, then writes to addr 0..2 with `last_i` on addr 2 and `blk_size_i=150` -> `nwords_o=3`, `blk_size_o=150`, 3 beats on consecutive cycles, `sop_o` on beat 0 and `eop_o` on beat 2, `valid_o` rising 1 cycle after close.
- `blk_size_i=2` on a single write to addr 0 -> one beat with `sop_o=eop_o=1` and `nwords_o=1`.
- Two 16-word blocks written back-to-back with `ready_i=0`, then `ready_i=1` -> 32 beats, no gap at the block boundary, and `overflow_o` stays 0.
- Both banks full, then a third block is written -> `overflow_o=1`; the first two blocks drain intact and the third block is never output.
- `ready_i` toggled randomly with 50% probability during a 5-word block -> `data_o`, `sop_o` and `eop_o` stable while stalled, and exactly 5 handshakes in order.
- `blk_size_i=1500` -> `blk_size_o=1024`, `nwords_o=16`, `overflow_o=1`; asserting `rst_n` low mid-drain -> all outputs 0 immediately.
